// File: rtl/tt_um_uart_tx.sv
// UART transmitter: 8N1 frames from ui_in on a rising edge of uio_in[0].
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1, 11-bit frame).
module tt_um_uart_tx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  localparam logic [9:0] BIT_LAST = 10'(CLKS_PER_BIT - 1);

  state_t     state, state_next;
  logic [9:0] cnt, cnt_next;
  logic [2:0] idx, idx_next;
  logic [7:0] shift, shift_next;
  logic [2:0] sync;
  logic [1:0] prime;
  logic       txd_r, busy_r, done_r;
  logic       txd_next, busy_next, done_next;
  logic       strobe_edge;
`ifdef UART_TX_PARITY_EN
  logic       par, par_next;
`endif

  // Upper uio bits carry no function.
  logic unused_uio;
  assign unused_uio = &{1'b0, uio_in[7:1]};

  // prime saturates once sync[2] holds a genuinely sampled value, so a strobe
  // already high at reset release is not mistaken for an edge.
  assign strobe_edge = sync[1] & ~sync[2] & (prime == 2'd3);

  // State register, synchroniser and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 10'd0;
      idx    <= 3'd0;
      shift  <= 8'd0;
      sync   <= 3'd0;
      prime  <= 2'd0;
      txd_r  <= 1'b1;
      busy_r <= 1'b0;
      done_r <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      idx    <= idx_next;
      shift  <= shift_next;
      sync   <= {sync[1:0], uio_in[0]};
      prime  <= (prime == 2'd3) ? prime : prime + 2'd1;
      txd_r  <= txd_next;
      busy_r <= busy_next;
      done_r <= done_next;
`ifdef UART_TX_PARITY_EN
      par    <= par_next;
`endif
    end
  end

  // Next-state logic: bit timing, data index and shift register.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    shift_next = shift;
`ifdef UART_TX_PARITY_EN
    par_next   = par;
`endif
    if (!ena) begin
      state_next = IDLE;
      cnt_next   = 10'd0;
      idx_next   = 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (strobe_edge) begin
            state_next = START;
            cnt_next   = BIT_LAST;
            idx_next   = 3'd0;
            shift_next = ui_in;
`ifdef UART_TX_PARITY_EN
            par_next   = even_parity(ui_in);
`endif
          end else begin
            cnt_next = 10'd0;
          end
        end
        START: begin
          if (cnt == 10'd0) begin
            state_next = DATA;
            cnt_next   = BIT_LAST;
          end else begin
            cnt_next = cnt - 10'd1;
          end
        end
        DATA: begin
          if (cnt == 10'd0) begin
            cnt_next   = BIT_LAST;
            shift_next = {1'b0, shift[7:1]};
            if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
              idx_next = 3'd0;
            end else begin
              idx_next = idx + 3'd1;
            end
          end else begin
            cnt_next = cnt - 10'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (cnt == 10'd0) begin
            state_next = STOP;
            cnt_next   = BIT_LAST;
          end else begin
            cnt_next = cnt - 10'd1;
          end
        end
`endif
        STOP: begin
          if (cnt == 10'd0) begin
            state_next = IDLE;
            cnt_next   = 10'd0;
          end else begin
            cnt_next = cnt - 10'd1;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = 10'd0;
          idx_next   = 3'd0;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so the flops present it in-cycle.
  always_comb begin
    txd_next  = 1'b1;
    busy_next = 1'b0;
    case (state_next)
      IDLE: begin
        txd_next  = 1'b1;
        busy_next = 1'b0;
      end
      START: begin
        txd_next  = 1'b0;
        busy_next = 1'b1;
      end
      DATA: begin
        txd_next  = shift_next[0];
        busy_next = 1'b1;
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        txd_next  = par_next;
        busy_next = 1'b1;
      end
`endif
      STOP: begin
        txd_next  = 1'b1;
        busy_next = 1'b1;
      end
      default: begin
        txd_next  = 1'b1;
        busy_next = 1'b0;
      end
    endcase
    done_next = ena & (state == STOP) & (state_next == IDLE);
  end

  assign uo_out  = {5'b00000, done_r, busy_r, txd_r};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_uart_tx.sv
// Directed bench for tt_um_uart_tx at CLKS_PER_BIT=4; every frame cycle is checked.
module tb_tt_um_uart_tx;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  wire  [7:0] uo_out;
  wire  [7:0] uio_out;
  wire  [7:0] uio_oe;

  int checks = 0;
  int failures = 0;

  tt_um_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line level expected at bit position pos of a frame carrying d.
  function automatic logic exp_bit(input logic [7:0] d, input int pos);
    if (pos == 0) return 1'b0;
    else if (pos <= 8) return d[pos-1];
`ifdef UART_TX_PARITY_EN
    else if (pos == 9) return ^d;
`endif
    else return 1'b1;
  endfunction

  // Raise the strobe for two sampled cycles; returns just after START entry.
  task automatic start_frame(input logic [7:0] d);
    ui_in = d;
    uio_in[0] = 1'b1;
    tick();
    check_eq("lat_e1", uo_out, 8'h01);
    tick();
    check_eq("lat_e2", uo_out, 8'h01);
    uio_in[0] = 1'b0;
    tick();
  endtask

  // abort_kind: 1 = reset pulse, 2 = ena low for one cycle.
  task automatic frame_body(input logic [7:0] d, input int inj_k, input int chg_k,
                            input logic [7:0] chg_v, input int abort_k,
                            input int abort_kind, input bit chain);
    for (int k = 0; k < NB*CPB; k++) begin
      check_eq("txd", {31'd0, uo_out[0]}, {31'd0, exp_bit(d, k/CPB)});
      check_eq("busy", {31'd0, uo_out[1]}, 32'd1);
      check_eq("done_mid", {31'd0, uo_out[2]}, 32'd0);
      check_eq("const0", {uo_out[7:3], uio_out, uio_oe}, 32'd0);
      if (k == abort_k) begin
        if (abort_kind == 1) begin
          rst_n = 1'b0;
          #1;
          check_eq("rst_async", uo_out, 8'h01);
          tick();
          rst_n = 1'b1;
        end else begin
          ena = 1'b0;
          tick();
          check_eq("ena_idle", uo_out, 8'h01);
          ena = 1'b1;
        end
        for (int j = 0; j < 6; j++) begin
          tick();
          check_eq("post_abort", {uo_out[7:3], uo_out[2:0], uio_out, uio_oe}, 32'h01_0000);
        end
        return;
      end
      if (k == inj_k) uio_in[0] = 1'b1;
      if (k == inj_k + 2) uio_in[0] = 1'b0;
      if (k == chg_k) ui_in = chg_v;
      tick();
    end
    uio_in[0] = 1'b0;
    check_eq("done", uo_out, 8'h05);
    tick();
    if (!chain) begin
      for (int j = 0; j < 6; j++) begin
        check_eq("idle_after", uo_out, 8'h01);
        tick();
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h01;
    tick();
    check_eq("rst_uo", uo_out, 8'h01);
    check_eq("rst_uio", {uio_out, uio_oe}, 32'd0);
    tick();
    rst_n = 1'b1;
    // Strobe already high at release must not start a frame.
    for (int j = 0; j < 6; j++) begin
      tick();
      check_eq("no_edge_rel", uo_out, 8'h01);
    end
    uio_in = 8'hAA;
    tick();
    tick();

    start_frame(8'hA5);
    frame_body(8'hA5, -10, -1, 8'h00, -1, 0, 1'b0);

    start_frame(8'h3C);
    frame_body(8'h3C, 4*CPB, -1, 8'h00, -1, 0, 1'b0);

    start_frame(8'h00);
    frame_body(8'h00, -10, 5, 8'hFF, -1, 0, 1'b0);

    start_frame(8'hC3);
    frame_body(8'hC3, -10, -1, 8'h00, 5*CPB + 1, 1, 1'b0);
    start_frame(8'h5A);
    frame_body(8'h5A, -10, -1, 8'h00, -1, 0, 1'b0);

    start_frame(8'h07);
    frame_body(8'h07, -10, -1, 8'h00, (NB-1)*CPB + 1, 2, 1'b0);
    start_frame(8'h07);
    frame_body(8'h07, -10, -1, 8'h00, -1, 0, 1'b0);

    start_frame(8'h5A);
    frame_body(8'h5A, NB*CPB - 2, NB*CPB - 1, 8'h81, -1, 0, 1'b1);
    frame_body(8'h81, -10, -1, 8'h00, -1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tt_um_uart_tx.md
TT_UM_UART_TX -- requirements
Module: tt_um_uart_tx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, default 87, clk cycles per UART bit (115200 baud at 10 MHz); legal range 2..1023.
REQ-002 SHALL have port: clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: ena  input  1  design enable; low forces IDLE.
REQ-005 SHALL have port: ui_in  input  8  transmit data byte, LSB sent first.
REQ-006 SHALL have port: uio_in  input  8  bit 0 = send strobe (asynchronous, level); bits 7:1 ignored.
REQ-007 SHALL have port: uo_out  output  8  bit 0 = txd, bit 1 = busy, bit 2 = done, bits 7:3 = 0.
REQ-008 SHALL have port: uio_out  output  8  constant 8'h00.
REQ-009 SHALL have port: uio_oe  output  8  constant 8'h00, all uio pins are inputs.

Function
REQ-010 SHALL synchronise uio_in[0] through two flops, then detect a rising edge against a third flop.
REQ-011 SHALL use FSM states IDLE, START, DATA, STOP, plus PARITY when UART_TX_PARITY_EN is defined.
REQ-012 SHALL, in IDLE with a detected strobe edge and ena=1, capture ui_in into a shift register and enter START.
REQ-013 SHALL drive txd low on the 3rd rising clk edge, counting the first edge that samples uio_in[0]=1.
REQ-014 SHALL hold each bit for exactly CLKS_PER_BIT cycles, timed by a bit-cycle counter that reloads on every state or bit change.
REQ-015 SHALL send START as txd=0, then DATA bits 0..7 LSB first, then STOP as txd=1.
REQ-016 SHALL use a 3-bit data-bit index and leave DATA after index 7 completes.
REQ-017 SHALL drive txd=1 in IDLE.
REQ-018 SHALL drive busy=1 in every state except IDLE.
REQ-019 SHALL pulse done high for exactly one cycle, on the cycle after the last STOP cycle (first IDLE cycle).
REQ-020 SHALL drop strobe edges that occur while busy=1 (no queueing); ui_in changes after capture SHALL NOT affect the frame in progress.
REQ-021 SHALL accept a strobe edge in the same cycle done is high.
REQ-022 SHALL, when ena=0 at any point, return to IDLE next edge with txd=1, busy=0, done=0, frame aborted, and no done pulse.
REQ-023 SHALL register txd, busy and done so that none is driven combinationally from inputs.

Reset
REQ-024 SHALL, while rst_n=0, force state=IDLE, txd=1, busy=0, done=0, counters=0, shift register=0, sync flops=0, asynchronously.
REQ-025 SHALL, on reset mid-frame, drive txd high immediately and discard the frame.
REQ-026 SHALL NOT detect a strobe edge on the first cycle after reset release if uio_in[0] is already high; an edge requires a sampled 0 then 1.

Configuration
REQ-027 SHALL, with UART_TX_PARITY_EN defined, insert a PARITY bit of CLKS_PER_BIT cycles between DATA and STOP, carrying even parity (XOR of the 8 data bits); frame = 11 bits.
REQ-028 SHALL, without UART_TX_PARITY_EN, omit PARITY state and logic; frame = 10 bits.

Verification (CLKS_PER_BIT=4)
REQ-029 SHALL cover: ui_in=8'hA5, strobe 0->1 held 2 cycles -> txd low at edge 3, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop 1; done pulses 1 cycle at 40 cycles after START entry (44 with parity, parity bit=0).
REQ-030 SHALL cover: strobe edge at bit 3 of a frame for 8'h3C -> frame unchanged, no second frame, single done pulse.
REQ-031 SHALL cover: ui_in changed 8'h00->8'hFF at cycle 5 of an 8'h00 frame -> all data bits 0.
REQ-032 SHALL cover: rst_n low at DATA bit 4 -> txd=1 and busy=0 within the same cycle, no done; new frame after release transmits correctly.
REQ-033 SHALL cover: ena low for 1 cycle during STOP -> IDLE, no done pulse; uio_oe=uio_out=8'h00 and uo_out[7:3]=0 throughout.
REQ-034 SHALL cover: strobe re-asserted in the done cycle with ui_in=8'h81 -> second frame begins with no idle bit beyond the sync latency; with parity, parity bit=0.
